// File: rtl/ddr_burst_arbiter.sv
// N-channel burst arbiter in front of the single rd/wr burst port of ddr_controller.
// Round-robin or fixed-priority selection, length clamp with sticky error, zero-length completion.
module ddr_burst_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int LEN_WIDTH      = 10,
  parameter int MAX_BURST_LEN  = 64,
  parameter int ARB_MODE       = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               init_calib_complete,
  input  logic [NUM_CH-1:0]                  ch_rd_req,
  input  logic [NUM_CH-1:0]                  ch_wr_req,
  input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_rd_len,
  input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_wr_len,
  input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_rd_addr,
  input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_wr_addr,
  input  logic [NUM_CH*DDR_DATA_WIDTH-1:0]   ch_wr_data,
  output logic [DDR_DATA_WIDTH-1:0]          ch_rd_data,
  output logic [NUM_CH-1:0]                  ch_rd_data_valid,
  output logic [NUM_CH-1:0]                  ch_wr_data_req,
  output logic [NUM_CH-1:0]                  ch_rd_finish,
  output logic [NUM_CH-1:0]                  ch_wr_finish,
  output logic [NUM_CH-1:0]                  ch_grant,
  output logic                               busy,
  output logic                               err_len,
  output logic                               rd_burst_req,
  output logic                               wr_burst_req,
  output logic [LEN_WIDTH-1:0]               rd_burst_len,
  output logic [LEN_WIDTH-1:0]               wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
  output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data,
  input  logic [DDR_DATA_WIDTH-1:0]          rd_burst_data,
  input  logic                               rd_burst_data_valid,
  input  logic                               wr_burst_data_req,
  input  logic                               rd_burst_finish,
  input  logic                               wr_burst_finish
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST_LEN);

  typedef enum logic [1:0] {IDLE, RD, WR, ZLEN} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             owner;
  logic                         owner_wr;
  logic [IDX_W-1:0]             rr_ptr;
  logic [NUM_CH-1:0]            req_any;
  logic                         win_found;
  logic [IDX_W-1:0]             win_idx;
  logic                         win_wr;
  logic [LEN_WIDTH-1:0]         raw_len;
  logic [LEN_WIDTH-1:0]         win_len;
  logic [DDR_ADDR_WIDTH-1:0]    win_addr;
  logic                         win_clamp;
  int                           cand;
  logic [IDX_W-1:0]             cand_idx;
  logic [IDX_W-1:0]             next_ptr;

  logic [LEN_WIDTH-1:0]         rd_len_a  [NUM_CH];
  logic [LEN_WIDTH-1:0]         wr_len_a  [NUM_CH];
  logic [DDR_ADDR_WIDTH-1:0]    rd_addr_a [NUM_CH];
  logic [DDR_ADDR_WIDTH-1:0]    wr_addr_a [NUM_CH];
  logic [DDR_DATA_WIDTH-1:0]    wr_data_a [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign rd_len_a[gi]  = ch_rd_len[gi*LEN_WIDTH +: LEN_WIDTH];
    assign wr_len_a[gi]  = ch_wr_len[gi*LEN_WIDTH +: LEN_WIDTH];
    assign rd_addr_a[gi] = ch_rd_addr[gi*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
    assign wr_addr_a[gi] = ch_wr_addr[gi*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
    assign wr_data_a[gi] = ch_wr_data[gi*DDR_DATA_WIDTH +: DDR_DATA_WIDTH];
  end

  assign req_any  = ch_rd_req | ch_wr_req;
  assign next_ptr = (owner == IDX_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;

  // Winner search starts at rr_ptr (round-robin) or 0 (fixed priority) and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (ARB_MODE == 1) ? k : int'(rr_ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_any[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_wr    = ch_wr_req[win_idx];
    raw_len   = win_wr ? wr_len_a[win_idx] : rd_len_a[win_idx];
    win_addr  = win_wr ? wr_addr_a[win_idx] : rd_addr_a[win_idx];
    win_clamp = raw_len > MAX_LEN;
    win_len   = win_clamp ? MAX_LEN : raw_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= '0;
      owner_wr      <= 1'b0;
      rr_ptr        <= '0;
      err_len       <= 1'b0;
      ch_grant      <= '0;
      busy          <= 1'b0;
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      wr_burst_len  <= '0;
      rd_burst_addr <= '0;
      wr_burst_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_calib_complete && win_found) begin
            owner    <= win_idx;
            owner_wr <= win_wr;
            ch_grant <= NUM_CH'(1) << win_idx;
            busy     <= 1'b1;
            if (win_clamp) err_len <= 1'b1;
            if (win_len == '0) begin
              state <= ZLEN;
            end else if (win_wr) begin
              state         <= WR;
              wr_burst_req  <= 1'b1;
              wr_burst_len  <= win_len;
              wr_burst_addr <= win_addr;
            end else begin
              state         <= RD;
              rd_burst_req  <= 1'b1;
              rd_burst_len  <= win_len;
              rd_burst_addr <= win_addr;
            end
          end
        end
        RD: begin
          if (rd_burst_finish) begin
            state        <= IDLE;
            rd_burst_req <= 1'b0;
            ch_grant     <= '0;
            busy         <= 1'b0;
            rr_ptr       <= next_ptr;
          end
        end
        WR: begin
          if (wr_burst_finish) begin
            state        <= IDLE;
            wr_burst_req <= 1'b0;
            ch_grant     <= '0;
            busy         <= 1'b0;
            rr_ptr       <= next_ptr;
          end
        end
        default: begin
          state    <= IDLE;
          ch_grant <= '0;
          busy     <= 1'b0;
          rr_ptr   <= next_ptr;
        end
      endcase
    end
  end

  // Beat strobes and completions pass straight through to the owner only; reset suppresses completion.
  assign ch_rd_data       = rd_burst_data;
  assign ch_rd_data_valid = (state == RD) ? (ch_grant & {NUM_CH{rd_burst_data_valid}}) : '0;
  assign ch_wr_data_req   = (state == WR) ? (ch_grant & {NUM_CH{wr_burst_data_req}}) : '0;
  assign wr_burst_data    = (state == WR) ? wr_data_a[owner] : '0;
  assign ch_rd_finish     = (!rst && ((state == RD && rd_burst_finish) ||
                                      (state == ZLEN && !owner_wr))) ? ch_grant : '0;
  assign ch_wr_finish     = (!rst && ((state == WR && wr_burst_finish) ||
                                      (state == ZLEN && owner_wr))) ? ch_grant : '0;
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Bench for ddr_burst_arbiter: one round-robin and one fixed-priority instance, each with a
// requester model, a ddr_controller responder and a scoreboard monitor checking grants and beats.
module tb_ddr_burst_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int AW = 28;
  localparam int LW = 10;
  localparam int IW = 2;

  typedef struct {
    bit wr;
    int ch;
    int len;
    int addr;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic init;
  logic [N*DW-1:0] wdata;

  logic [N-1:0]    rd_req [2];
  logic [N-1:0]    wr_req [2];
  logic [LW-1:0]   rd_len_a  [2][N];
  logic [LW-1:0]   wr_len_a  [2][N];
  logic [AW-1:0]   rd_addr_a [2][N];
  logic [AW-1:0]   wr_addr_a [2][N];
  logic [N*LW-1:0] rd_len [2];
  logic [N*LW-1:0] wr_len [2];
  logic [N*AW-1:0] rd_addr [2];
  logic [N*AW-1:0] wr_addr [2];

  logic [DW-1:0] ch_rd_data_o [2];
  logic [N-1:0]  ch_rd_data_valid_o [2];
  logic [N-1:0]  ch_wr_data_req_o [2];
  logic [N-1:0]  ch_rd_finish_o [2];
  logic [N-1:0]  ch_wr_finish_o [2];
  logic [N-1:0]  ch_grant_o [2];
  logic          busy_o [2];
  logic          err_len_o [2];
  logic          rd_breq_o [2];
  logic          wr_breq_o [2];
  logic [LW-1:0] rd_blen_o [2];
  logic [LW-1:0] wr_blen_o [2];
  logic [AW-1:0] rd_baddr_o [2];
  logic [AW-1:0] wr_baddr_o [2];
  logic [DW-1:0] wr_bdata_o [2];

  logic [DW-1:0] rd_bdata [2];
  logic          rd_bvalid [2];
  logic          wr_bdreq [2];
  logic          rd_bfin [2];
  logic          wr_bfin [2];

  txn_t pend [2][$];
  txn_t sbq  [2][$];
  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] wpat(int ch);
    return {16{8'(8'h30 + ch)}};
  endfunction

  task automatic check(string name, logic [255:0] got, logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [255:0] outs(int d);
    return 256'({ch_grant_o[d], busy_o[d], err_len_o[d], rd_breq_o[d], wr_breq_o[d],
                 rd_blen_o[d], wr_blen_o[d], rd_baddr_o[d], wr_baddr_o[d],
                 ch_rd_data_valid_o[d], ch_wr_data_req_o[d], ch_rd_finish_o[d],
                 ch_wr_finish_o[d], wr_bdata_o[d]});
  endfunction

  task automatic req(int d, int ch, bit wr, int len, int addr);
    txn_t t;
    t.wr = wr; t.ch = ch; t.len = len; t.addr = addr;
    pend[d].push_back(t);
  endtask

  task automatic expect_txn(int d, int ch, bit wr, int len, int addr);
    txn_t t;
    t.wr = wr; t.ch = ch; t.len = len; t.addr = addr;
    sbq[d].push_back(t);
  endtask

  task automatic wait_done(int d);
    bit timeout;
    timeout = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (sbq[d].size() == 0 && pend[d].size() == 0 && rd_req[d] == '0 &&
          wr_req[d] == '0 && !busy_o[d]) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("done_timeout_d%0d", d), 256'(timeout), 256'(1'b0));
  endtask

  for (genvar gi = 0; gi < N; gi++) begin : g_wdata
    assign wdata[gi*DW +: DW] = wpat(gi);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    for (genvar gk = 0; gk < N; gk++) begin : g_pack
      assign rd_len[gi][gk*LW +: LW]  = rd_len_a[gi][gk];
      assign wr_len[gi][gk*LW +: LW]  = wr_len_a[gi][gk];
      assign rd_addr[gi][gk*AW +: AW] = rd_addr_a[gi][gk];
      assign wr_addr[gi][gk*AW +: AW] = wr_addr_a[gi][gk];
    end

    ddr_burst_arbiter #(
      .NUM_CH(N), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW),
      .LEN_WIDTH(LW), .MAX_BURST_LEN(64), .ARB_MODE(gi)
    ) u_dut (
      .clk(clk), .rst(rst), .init_calib_complete(init),
      .ch_rd_req(rd_req[gi]), .ch_wr_req(wr_req[gi]),
      .ch_rd_len(rd_len[gi]), .ch_wr_len(wr_len[gi]),
      .ch_rd_addr(rd_addr[gi]), .ch_wr_addr(wr_addr[gi]),
      .ch_wr_data(wdata),
      .ch_rd_data(ch_rd_data_o[gi]), .ch_rd_data_valid(ch_rd_data_valid_o[gi]),
      .ch_wr_data_req(ch_wr_data_req_o[gi]),
      .ch_rd_finish(ch_rd_finish_o[gi]), .ch_wr_finish(ch_wr_finish_o[gi]),
      .ch_grant(ch_grant_o[gi]), .busy(busy_o[gi]), .err_len(err_len_o[gi]),
      .rd_burst_req(rd_breq_o[gi]), .wr_burst_req(wr_breq_o[gi]),
      .rd_burst_len(rd_blen_o[gi]), .wr_burst_len(wr_blen_o[gi]),
      .rd_burst_addr(rd_baddr_o[gi]), .wr_burst_addr(wr_baddr_o[gi]),
      .wr_burst_data(wr_bdata_o[gi]),
      .rd_burst_data(rd_bdata[gi]), .rd_burst_data_valid(rd_bvalid[gi]),
      .wr_burst_data_req(wr_bdreq[gi]),
      .rd_burst_finish(rd_bfin[gi]), .wr_burst_finish(wr_bfin[gi])
    );

    // Responder drives downstream inputs at negedge; monitor and requester act 1ns later.
    initial begin : proc
      int phase, delay, remain, beats, beatnum;
      bit active, prev_busy, stray;
      logic [N-1:0] oh;
      txn_t cur, t;
      txn_t nq[$];
      phase = 0; delay = 0; remain = 0; beats = 0; beatnum = 0;
      active = 1'b0; prev_busy = 1'b0; stray = 1'b0; oh = '0;
      cur.wr = 1'b0; cur.ch = 0; cur.len = 0; cur.addr = 0;
      rd_req[gi] = '0; wr_req[gi] = '0;
      for (int k = 0; k < N; k++) begin
        rd_len_a[gi][k] = '0; wr_len_a[gi][k] = '0;
        rd_addr_a[gi][k] = '0; wr_addr_a[gi][k] = '0;
      end
      rd_bdata[gi] = '0; rd_bvalid[gi] = 1'b0; wr_bdreq[gi] = 1'b0;
      rd_bfin[gi] = 1'b0; wr_bfin[gi] = 1'b0;
      forever begin
        @(negedge clk);
        rd_bvalid[gi] = 1'b0; rd_bfin[gi] = 1'b0; wr_bdreq[gi] = 1'b0; wr_bfin[gi] = 1'b0;
        if (rst) begin
          phase = 0;
        end else if (phase == 0) begin
          if (rd_breq_o[gi] || wr_breq_o[gi]) begin
            phase = 1;
            delay = 2;
            remain = rd_breq_o[gi] ? int'(rd_blen_o[gi]) : int'(wr_blen_o[gi]);
          end
        end else if (phase == 1) begin
          if (delay > 0) begin
            delay--;
          end else if (remain > 0) begin
            remain--;
            if (rd_breq_o[gi]) begin
              rd_bvalid[gi] = 1'b1;
              rd_bdata[gi] = {4{32'(beatnum + 32'h1000)}};
              beatnum++;
            end else begin
              wr_bdreq[gi] = 1'b1;
            end
          end else begin
            if (rd_breq_o[gi]) rd_bfin[gi] = 1'b1;
            else wr_bfin[gi] = 1'b1;
            phase = 2;
          end
        end else if (!rd_breq_o[gi] && !wr_breq_o[gi]) begin
          phase = 0;
        end
        #1;
        if (rst) begin
          active = 1'b0;
          prev_busy = 1'b0;
          rd_req[gi] = '0;
          wr_req[gi] = '0;
        end else begin
          if (busy_o[gi] && !prev_busy) begin
            if (sbq[gi].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_grant_d%0d: got %b want none", gi, ch_grant_o[gi]);
            end else begin
              cur = sbq[gi].pop_front();
              oh = N'(1) << cur.ch;
              check($sformatf("grant_d%0d_ch%0d", gi, cur.ch),
                    256'({ch_grant_o[gi], rd_breq_o[gi], wr_breq_o[gi],
                          ch_rd_finish_o[gi], ch_wr_finish_o[gi]}),
                    256'({oh, !cur.wr && cur.len != 0, cur.wr && cur.len != 0,
                          oh & {N{!cur.wr && cur.len == 0}},
                          oh & {N{cur.wr && cur.len == 0}}}));
              if (cur.len != 0)
                check($sformatf("len_addr_d%0d_ch%0d", gi, cur.ch),
                      256'({cur.wr ? wr_blen_o[gi] : rd_blen_o[gi],
                            cur.wr ? wr_baddr_o[gi] : rd_baddr_o[gi]}),
                      256'({LW'(cur.len), AW'(cur.addr)}));
              active = (cur.len != 0);
              beats = 0;
              stray = 1'b0;
            end
          end
          if (active) begin
            oh = N'(1) << cur.ch;
            if (!cur.wr) begin
              if (ch_rd_data_valid_o[gi][IW'(cur.ch)]) beats++;
              if ((ch_rd_data_valid_o[gi] & ~oh) != '0 || ch_rd_data_o[gi] !== rd_bdata[gi])
                stray = 1'b1;
              if (rd_bfin[gi]) begin
                check($sformatf("rd_done_d%0d_ch%0d", gi, cur.ch),
                      256'({ch_rd_finish_o[gi], 16'(beats), stray}),
                      256'({oh, 16'(cur.len), 1'b0}));
                active = 1'b0;
              end
            end else begin
              if (ch_wr_data_req_o[gi][IW'(cur.ch)]) begin
                beats++;
                if (wr_bdata_o[gi] !== wpat(cur.ch)) stray = 1'b1;
              end
              if ((ch_wr_data_req_o[gi] & ~oh) != '0) stray = 1'b1;
              if (wr_bfin[gi]) begin
                check($sformatf("wr_done_d%0d_ch%0d", gi, cur.ch),
                      256'({ch_wr_finish_o[gi], 16'(beats), stray}),
                      256'({oh, 16'(cur.len), 1'b0}));
                active = 1'b0;
              end
            end
          end
          prev_busy = busy_o[gi];
          // Requesters hold their level until their finish pulse, then take the next queued job.
          rd_req[gi] = rd_req[gi] & ~ch_rd_finish_o[gi];
          wr_req[gi] = wr_req[gi] & ~ch_wr_finish_o[gi];
          nq = {};
          foreach (pend[gi][k]) begin
            t = pend[gi][k];
            if (t.wr ? wr_req[gi][IW'(t.ch)] : rd_req[gi][IW'(t.ch)]) begin
              nq.push_back(t);
            end else if (t.wr) begin
              wr_req[gi][IW'(t.ch)] = 1'b1;
              wr_len_a[gi][IW'(t.ch)] = LW'(t.len);
              wr_addr_a[gi][IW'(t.ch)] = AW'(t.addr);
            end else begin
              rd_req[gi][IW'(t.ch)] = 1'b1;
              rd_len_a[gi][IW'(t.ch)] = LW'(t.len);
              rd_addr_a[gi][IW'(t.ch)] = AW'(t.addr);
            end
          end
          pend[gi] = nq;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b1;
    init = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_outs_d0", outs(0), 256'(0));
    check("reset_outs_d1", outs(1), 256'(0));

    // No grant while calibration is incomplete, then single read with 1-cycle grant latency.
    req(0, 1, 1'b0, 4, 'h100);
    expect_txn(0, 1, 1'b0, 4, 'h100);
    repeat (6) @(negedge clk);
    #2;
    check("calib_gate", 256'({busy_o[0], ch_grant_o[0], rd_breq_o[0]}), 256'(0));
    @(negedge clk);
    init = 1'b1;
    @(posedge clk); #1;
    check("grant_latency", 256'({rd_breq_o[0], ch_grant_o[0], rd_blen_o[0], rd_baddr_o[0]}),
          256'({1'b1, 4'b0010, 10'd4, 28'h100}));
    wait_done(0);

    // Reset in the middle of a write burst.
    req(0, 3, 1'b1, 8, 'h300);
    expect_txn(0, 3, 1'b1, 8, 'h300);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_breq_o[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wr_start", 256'(ok), 256'(1'b1));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_midburst", 256'({wr_breq_o[0], busy_o[0], ch_grant_o[0], ch_wr_finish_o[0]}),
          256'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Round-robin from a freshly reset pointer; ch0 re-requests and is served last.
    req(0, 0, 1'b0, 2, 'h1000);
    req(0, 1, 1'b0, 3, 'h1040);
    req(0, 2, 1'b0, 2, 'h1080);
    req(0, 3, 1'b0, 1, 'h10c0);
    req(0, 0, 1'b0, 5, 'h2000);
    expect_txn(0, 0, 1'b0, 2, 'h1000);
    expect_txn(0, 1, 1'b0, 3, 'h1040);
    expect_txn(0, 2, 1'b0, 2, 'h1080);
    expect_txn(0, 3, 1'b0, 1, 'h10c0);
    expect_txn(0, 0, 1'b0, 5, 'h2000);
    wait_done(0);

    // Zero-length read completes without a downstream request.
    req(0, 2, 1'b0, 0, 'h55);
    expect_txn(0, 2, 1'b0, 0, 'h55);
    wait_done(0);

    // Same channel read+write: write first, clamped to 64 with sticky error.
    req(0, 0, 1'b0, 4, 'h400);
    req(0, 0, 1'b1, 100, 'h500);
    expect_txn(0, 0, 1'b1, 64, 'h500);
    expect_txn(0, 0, 1'b0, 4, 'h400);
    wait_done(0);
    check("err_len_set", 256'({err_len_o[0], err_len_o[1]}), 256'(2'b10));

    // Fixed priority: ch0 beats ch2; ch3 arrives mid-burst and waits behind ch0's re-request.
    req(1, 2, 1'b0, 3, 'h620);
    req(1, 0, 1'b0, 6, 'h600);
    expect_txn(1, 0, 1'b0, 6, 'h600);
    expect_txn(1, 0, 1'b0, 2, 'h610);
    expect_txn(1, 2, 1'b0, 3, 'h620);
    expect_txn(1, 3, 1'b0, 2, 'h630);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy_o[1]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("fp_start", 256'(ok), 256'(1'b1));
    req(1, 3, 1'b0, 2, 'h630);
    req(1, 0, 1'b0, 2, 'h610);
    wait_done(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
